// File: rtl/mux_chain_pkg.sv
// +----------------------------------------------------------------------+
// | mux_chain_pkg : shared mode encodings and select-width helper        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package mux_chain_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Width needed to index n items, never less than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mux_sel_ctrl.sv
// +----------------------------------------------------------------------+
// | mux_sel_ctrl : shared select register with manual load, dwell-timed  |
// | scan advance, wrap pulse and sticky out-of-range flag. Rev 1.0       |
// +----------------------------------------------------------------------+
`default_nettype none

module mux_sel_ctrl
  import mux_chain_pkg::*;
#(
  parameter int NIN   = 2,
  parameter int DWELL = 4,
  parameter int SW    = 1
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          mode_i,
  input  logic [SW-1:0] sel_i,
  input  logic          sel_load_i,
  output logic [SW-1:0] sel_o,
  output logic          wrap_o,
  output logic          sel_err_o
);

  localparam int            CW       = clog2_min1(DWELL);
  localparam logic [SW:0]   NIN_V    = (SW+1)'(NIN);
  localparam logic [SW-1:0] SEL_LAST = SW'(NIN - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

  logic [SW-1:0] sel_q, sel_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wrap_q, wrap_d;
  logic          err_q, err_d;
  logic          load_ok;

  assign load_ok = sel_load_i && ({1'b0, sel_i} < NIN_V);

  always_comb begin
    sel_d  = sel_q;
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    err_d  = err_q;
    if (load_ok) begin
      sel_d = sel_i;
      cnt_d = '0;
    end else begin
      // A rejected load must not disturb the dwell timing.
      if (sel_load_i) begin
        err_d = 1'b1;
      end
      if (mode_i == MODE_SCAN) begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (sel_q == SEL_LAST) begin
            sel_d  = '0;
            wrap_d = 1'b1;
          end else begin
            sel_d = sel_q + SW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end else begin
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sel_q  <= '0;
      cnt_q  <= '0;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      sel_q  <= sel_d;
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  assign sel_o     = sel_q;
  assign wrap_o    = wrap_q;
  assign sel_err_o = err_q;

endmodule

`default_nettype wire

// File: rtl/mux_chain_sel_seq.sv
// +----------------------------------------------------------------------+
// | mux_chain_sel_seq : CH registered NIN:1 muxes sharing one select     |
// | driven by mux_sel_ctrl. Rev 1.0                                      |
// +----------------------------------------------------------------------+
`default_nettype none

module mux_chain_sel_seq
  import mux_chain_pkg::*;
#(
  parameter int CH    = 2,
  parameter int NIN   = 2,
  parameter int W     = 1,
  parameter int DWELL = 4,
  localparam int SW   = clog2_min1(NIN)
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic [CH*NIN*W-1:0] data_in,
  input  logic                en_in,
  input  logic                mode_in,
  input  logic [SW-1:0]       sel_in,
  input  logic                sel_load_in,
  output logic [CH*W-1:0]     y_out,
  output logic                valid_out,
  output logic [SW-1:0]       sel_out,
  output logic                wrap_out,
  output logic                sel_err_out
);

  logic [SW-1:0]   sel_q;
  logic [CH*W-1:0] y_d, y_q;
  logic            valid_q;

  mux_sel_ctrl #(
    .NIN   (NIN),
    .DWELL (DWELL),
    .SW    (SW)
  ) u_sel_ctrl (
    .clk_i      (clk_in),
    .rst_n_i    (rst_n_in),
    .mode_i     (mode_in),
    .sel_i      (sel_in),
    .sel_load_i (sel_load_in),
    .sel_o      (sel_q),
    .wrap_o     (wrap_out),
    .sel_err_o  (sel_err_out)
  );

  // Muxes use the select as it stands before the edge, so a load shows up
  // in the data one cycle after it shows up on sel_out.
  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic [W-1:0] ch_mux;
    always_comb begin
      ch_mux = '0;
      for (int i = 0; i < NIN; i++) begin
        if (sel_q == SW'(i)) begin
          ch_mux = data_in[((c*NIN)+i)*W +: W];
        end
      end
    end
    assign y_d[c*W +: W] = ch_mux;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      y_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= en_in;
      if (en_in) begin
        y_q <= y_d;
      end
    end
  end

  assign y_out     = y_q;
  assign valid_out = valid_q;
  assign sel_out   = sel_q;

endmodule

`default_nettype wire

// File: tb/tb_mux_chain_sel_seq.sv
// +----------------------------------------------------------------------+
// | tb_mux_chain_sel_seq : vector table, directed corners and random     |
// | stimulus against a cycle-level reference model. Rev 1.0              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_mux_chain_sel_seq;

  logic clk;
  logic rst_n;

  // DUT A: CH=2 NIN=4 W=8 DWELL=3
  logic [63:0] a_data;
  logic        a_en, a_mode, a_load;
  logic [1:0]  a_sel_in;
  logic [15:0] a_y;
  logic        a_valid, a_wrap, a_err;
  logic [1:0]  a_sel;

  // DUT B: CH=2 NIN=3 W=8 DWELL=1 (reaches out-of-range select codes)
  logic [63:0] b_data;
  logic        b_en, b_mode, b_load;
  logic [1:0]  b_sel_in;
  logic [15:0] b_y;
  logic        b_valid, b_wrap, b_err;
  logic [1:0]  b_sel;

  mux_chain_sel_seq #(.CH(2), .NIN(4), .W(8), .DWELL(3)) u_dut_a (
    .clk_in(clk), .rst_n_in(rst_n), .data_in(a_data), .en_in(a_en),
    .mode_in(a_mode), .sel_in(a_sel_in), .sel_load_in(a_load),
    .y_out(a_y), .valid_out(a_valid), .sel_out(a_sel),
    .wrap_out(a_wrap), .sel_err_out(a_err)
  );

  mux_chain_sel_seq #(.CH(2), .NIN(3), .W(8), .DWELL(1)) u_dut_b (
    .clk_in(clk), .rst_n_in(rst_n), .data_in(b_data[47:0]), .en_in(b_en),
    .mode_in(b_mode), .sel_in(b_sel_in), .sel_load_in(b_load),
    .y_out(b_y), .valid_out(b_valid), .sel_out(b_sel),
    .wrap_out(b_wrap), .sel_err_out(b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          sel;
    int          held;
    bit          err;
    bit          wrap;
    bit          valid;
    logic [15:0] y;
  } mstate_t;

  typedef struct {
    logic        ld;
    logic [1:0]  sel;
    logic        en;
    logic [63:0] data;
    logic [1:0]  e_sel;
    logic [15:0] e_y;
    logic        e_valid;
  } vec_t;

  mstate_t ma, mb;
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic mstate_t mreset();
    mstate_t s;
    s.sel = 0; s.held = 0; s.err = 0; s.wrap = 0; s.valid = 0; s.y = '0;
    return s;
  endfunction

  // One rising edge of the behavioural model: data picks with the old select,
  // then the select obeys load > scan-advance > hold.
  task automatic step(inout mstate_t s, input int nin, input int dwell,
                      input logic ld, input int si, input logic en,
                      input logic mode, input logic [63:0] d);
    int old;
    logic [63:0] tmp;
    old = s.sel;
    if (en) begin
      for (int c = 0; c < 2; c++) begin
        tmp = d >> (((c * nin) + old) * 8);
        s.y[c*8 +: 8] = tmp[7:0];
      end
    end
    s.valid = en;
    s.wrap  = 0;
    if (ld && si < nin) begin
      s.sel  = si;
      s.held = 0;
    end else begin
      if (ld) s.err = 1;
      if (mode) begin
        s.held++;
        if (s.held == dwell) begin
          s.held = 0;
          s.sel  = (s.sel + 1) % nin;
          s.wrap = (s.sel == 0);
        end
      end else begin
        s.held = 0;
      end
    end
  endtask

  task automatic check_models();
    chk("a_y", a_y, ma.y);
    chk("a_valid", a_valid, ma.valid);
    chk("a_sel", a_sel, ma.sel[1:0]);
    chk("a_wrap", a_wrap, ma.wrap);
    chk("a_err", a_err, ma.err);
    chk("b_y", b_y, mb.y);
    chk("b_valid", b_valid, mb.valid);
    chk("b_sel", b_sel, mb.sel[1:0]);
    chk("b_wrap", b_wrap, mb.wrap);
    chk("b_err", b_err, mb.err);
  endtask

  task automatic tick();
    @(posedge clk);
    step(ma, 4, 3, a_load, int'(a_sel_in), a_en, a_mode, a_data);
    step(mb, 3, 1, b_load, int'(b_sel_in), b_en, b_mode, b_data);
    #1;
    check_models();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_a_y"}, a_y, 0);
    chk({tag, "_a_valid"}, a_valid, 0);
    chk({tag, "_a_sel"}, a_sel, 0);
    chk({tag, "_a_wrap"}, a_wrap, 0);
    chk({tag, "_a_err"}, a_err, 0);
    chk({tag, "_b_err"}, b_err, 0);
    chk({tag, "_b_sel"}, b_sel, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    ma = mreset();
    mb = mreset();
    repeat (2) @(negedge clk);
    check_zero("reset");
    a_load = 0; a_mode = 0; a_en = 0;
    b_load = 0; b_mode = 0; b_en = 0;
    rst_n = 1'b1;
  endtask

  vec_t tbl[7];
  int   wraps;

  localparam logic [63:0] D1 = 64'h2322_2120_1312_1110;
  localparam logic [63:0] D2 = 64'h4746_4544_3736_3534;

  initial begin
    rst_n = 1'b0;
    a_data = D1; a_en = 0; a_mode = 0; a_load = 0; a_sel_in = 0;
    b_data = '0; b_en = 0; b_mode = 0; b_load = 0; b_sel_in = 0;
    ma = mreset();
    mb = mreset();

    // Manual select and en gating, expected values worked by hand.
    tbl[0] = '{ld:1, sel:2, en:1, data:D1, e_sel:2, e_y:16'h2010, e_valid:1};
    tbl[1] = '{ld:0, sel:0, en:1, data:D1, e_sel:2, e_y:16'h2212, e_valid:1};
    tbl[2] = '{ld:0, sel:0, en:0, data:D2, e_sel:2, e_y:16'h2212, e_valid:0};
    tbl[3] = '{ld:0, sel:0, en:0, data:D2, e_sel:2, e_y:16'h2212, e_valid:0};
    tbl[4] = '{ld:0, sel:0, en:1, data:D2, e_sel:2, e_y:16'h4636, e_valid:1};
    tbl[5] = '{ld:1, sel:3, en:1, data:D2, e_sel:3, e_y:16'h4636, e_valid:1};
    tbl[6] = '{ld:0, sel:0, en:1, data:D2, e_sel:3, e_y:16'h4737, e_valid:1};

    do_reset();
    for (int k = 0; k < 7; k++) begin
      a_load = tbl[k].ld; a_sel_in = tbl[k].sel; a_en = tbl[k].en; a_data = tbl[k].data;
      tick();
      chk($sformatf("tbl%0d_sel", k), a_sel, tbl[k].e_sel);
      chk($sformatf("tbl%0d_y", k), a_y, tbl[k].e_y);
      chk($sformatf("tbl%0d_valid", k), a_valid, tbl[k].e_valid);
    end
    a_load = 0;

    // Scan sweep from reset: each select held 3 cycles, wrap every 12.
    do_reset();
    a_mode = 1; a_en = 1; a_data = D1;
    wraps = 0;
    for (int t = 1; t <= 24; t++) begin
      tick();
      if (a_wrap) wraps++;
      chk($sformatf("sweep_wrap_t%0d", t), a_wrap, (t % 12) == 0);
      if (t % 3 == 0) chk($sformatf("sweep_sel_t%0d", t), a_sel, (t / 3) % 4);
    end
    chk("sweep_wrap_count", wraps, 2);

    // Load coincident with the advance edge that would wrap 3 -> 0.
    do_reset();
    a_mode = 1;
    repeat (11) tick();
    a_load = 1; a_sel_in = 1;
    tick();
    a_load = 0;
    chk("ldadv_sel", a_sel, 1);
    chk("ldadv_nowrap", a_wrap, 0);
    tick(); chk("ldadv_hold1", a_sel, 1);
    tick(); chk("ldadv_hold2", a_sel, 1);
    tick(); chk("ldadv_next", a_sel, 2);

    // Out-of-range load on the NIN=3 instance.
    do_reset();
    b_load = 1; b_sel_in = 2;
    tick(); chk("oor_inrange_sel", b_sel, 2);
    b_sel_in = 3;
    tick();
    chk("oor_sel_kept", b_sel, 2);
    chk("oor_err", b_err, 1);
    b_load = 0;
    repeat (3) tick();
    chk("oor_err_sticky", b_err, 1);
    do_reset();
    chk("oor_err_cleared", b_err, 0);

    // Asynchronous reset between edges while scanning.
    a_mode = 1; a_en = 1; a_data = D2;
    repeat (4) tick();
    #3;
    rst_n = 1'b0;
    #1;
    check_zero("async");
    ma = mreset();
    mb = mreset();
    @(negedge clk);
    rst_n = 1'b1;
    tick(); chk("post_rst_e1", a_sel, 0);
    tick(); chk("post_rst_e2", a_sel, 0);
    tick(); chk("post_rst_e3", a_sel, 1);

    // Random traffic on both instances.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      a_data = {$urandom, $urandom};
      b_data = {$urandom, $urandom};
      a_en = ($urandom_range(0, 3) != 0);
      b_en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) a_mode = ~a_mode;
      if ($urandom_range(0, 15) == 0) b_mode = ~b_mode;
      a_load = ($urandom_range(0, 7) == 0);
      b_load = ($urandom_range(0, 7) == 0);
      a_sel_in = 2'($urandom_range(0, 3));
      b_sel_in = 2'($urandom_range(0, 3));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
